elevator_request_queue: RTL and testbench
=========================================

Name: elevator_request_queue

Overview:
- Producer side of the floor-request interface consumed by the elevator controller.
- Synchronises and debounces the raw hall/car buttons, and drops presses for floors already pending.
- Queues accepted requests in arrival order and presents them one at a time on a valid/ready handshake.
- Drives the per-floor request lamps until the controller takes each request.

Parameters:
NUM_FLOORS, 7, number of buttons/floors (index 0 = ground floor)
FLOOR_W, 7, width of req_floor; matches the controller floor counter width
DEPTH, 8, FIFO entries; must be >= NUM_FLOORS (enforced by elaboration-time check)
DEB_CYCLES, 4, consecutive synchronised-high cycles required to accept a press (>= 1)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
button  in  NUM_FLOORS  raw asynchronous buttons, active-high, one bit per floor
req_ready  in  1  controller takes head request at an edge where req_valid && req_ready
req_valid  out  1  FIFO non-empty
req_floor  out  FLOOR_W  binary floor index of FIFO head, zero-extended; 0 when empty
lamp  out  NUM_FLOORS  lamp[i] = floor i staged or queued
count  out  $clog2(DEPTH)+1  FIFO occupancy
full  out  1  count == DEPTH

Behaviour:
- Reset (reset=0, asynchronous): sync flops, debounce FSMs, staged/queued masks, pointers and count clear; all outputs 0.
- Synchroniser: two flops per button; s2[i] is the synchronised value.
- Debounce FSM per button. States are ARMED, COUNT and HELD; the reset state is ARMED.
  - ARMED: if s2=1, cnt<=1 and go to COUNT; DEB_CYCLES=1 accepts immediately and goes to HELD.
  - COUNT: if s2=0, go to ARMED. If cnt==DEB_CYCLES-1 and s2=1, issue the accept pulse and go to HELD. Otherwise cnt++.
  - HELD: wait until s2=0, then go to ARMED. One accept per press; a held button never re-requests.
- Accept handling: on accept[i], staged[i] is set at that edge only if lamp[i]=0 (sampled before the edge). Otherwise the press is dropped.
  - Accept for floor i in the same cycle that floor i is popped: the press is dropped and the lamp goes off.
- Staging to FIFO: each cycle, if staged!=0 and !full, the lowest-index staged bit is written at the write pointer. That bit is cleared in staged and set in queued. One push per cycle maximum.
- Multiple simultaneous accepts are all staged, then enqueued lowest floor first on consecutive cycles.
- Pop: at an edge with req_valid && req_ready, the read pointer advances and queued[req_floor] clears.
  - Pop is ignored when empty, i.e. req_ready with req_valid=0 is harmless.
- Push and pop may occur in the same cycle; count is then unchanged.
- Pointers wrap modulo DEPTH. count is maintained explicitly, not derived from pointers.
- full stalls the staging step only; staged requests wait and their lamps stay lit. No request is ever lost.
- Outputs req_floor, req_valid, count and full are combinational from registered FIFO state. No output depends combinationally on req_ready or button.
- Latency: button high and stable before edge 1 gives staged after edge 2+DEB_CYCLES and req_valid=1 after edge 3+DEB_CYCLES. With defaults, staged after edge 6 and req_valid after edge 7.
- Reset mid-operation: queue is emptied and lamps go off. A button held through reset release is accepted again DEB_CYCLES cycles after synchronisation.

Test Plan:
- Single press: reset released, button=7'b0000100 held 10 cycles, req_ready=0 -> lamp[2]=1 after edge 6; after edge 7 req_valid=1, req_floor=2, count=1. Set req_ready=1 for one edge -> req_valid=0, lamp=0, count=0.
- Glitch rejection: button[3] high for 3 cycles then low -> no accept, lamp[3] stays 0. A later 10-cycle press of button[3] -> accepted normally.
- Duplicate and hold: floor 5 pressed, released, pressed again while still queued -> count stays 1. Held 50 cycles -> exactly one request.
- Simultaneous presses: button=7'b1010010 in one cycle, req_ready=0 -> FIFO order 1, 4, 6 on consecutive cycles; count=3; lamp=7'b1010010.
- Concurrent push/pop: FIFO holds {0,3}; floor 6 is enqueued on the same edge the head is popped -> count stays 2, head=3, then 6. Pointers wrap cleanly over 20 push/pop cycles with DEPTH=8.
- Async reset: assert reset mid-stream between clock edges with 3 queued and 1 staged -> all outputs 0 immediately. After release with no buttons pressed, nothing reappears.

Source files
------------

// File: rtl/elevator_request_queue.sv
// Floor-request producer: synchronises and debounces buttons, drops presses for floors
// already pending, and queues accepted floors in arrival order behind a valid/ready handshake.
module elevator_request_queue #(
  parameter int NUM_FLOORS = 7,
  parameter int FLOOR_W    = 7,
  parameter int DEPTH      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_FLOORS-1:0]   button,
  input  logic                    req_ready,
  output logic                    req_valid,
  output logic [FLOOR_W-1:0]      req_floor,
  output logic [NUM_FLOORS-1:0]   lamp,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {ARMED, COUNT, HELD} deb_state_t;

  if (DEPTH < NUM_FLOORS) begin : g_depth_check
    $error("elevator_request_queue: DEPTH must be >= NUM_FLOORS");
  end

  logic [NUM_FLOORS-1:0] s1_reg, s2_reg;
  logic [NUM_FLOORS-1:0] accept;
  logic [NUM_FLOORS-1:0] staged_reg, staged_next;
  logic [NUM_FLOORS-1:0] queued_reg, queued_next;
  logic [NUM_FLOORS-1:0] push_onehot, pop_mask;
  logic [FLOOR_W-1:0]    push_idx;
  logic                  push_found, push, pop;
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [FLOOR_W-1:0]    fifo_mem [DEPTH];
  logic [FLOOR_W-1:0]    head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= button;
      s2_reg <= s1_reg;
    end
  end

  for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_deb
    deb_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             acc;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_reg <= ARMED;
        cnt_reg   <= '0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
      end
    end

    // One accept per press: HELD swallows the remainder of a long press.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      acc        = 1'b0;
      case (state_reg)
        ARMED: begin
          if (s2_reg[gi]) begin
            if (DEB_CYCLES == 1) begin
              acc        = 1'b1;
              state_next = HELD;
            end else begin
              cnt_next   = CNT_W'(1);
              state_next = COUNT;
            end
          end
        end
        COUNT: begin
          if (!s2_reg[gi]) begin
            state_next = ARMED;
          end else if (cnt_reg == CNT_W'(DEB_CYCLES - 1)) begin
            acc        = 1'b1;
            state_next = HELD;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        HELD: begin
          if (!s2_reg[gi]) state_next = ARMED;
        end
        default: state_next = ARMED;
      endcase
    end

    assign accept[gi] = acc;
  end

  assign lamp      = staged_reg | queued_reg;
  assign req_valid = (count_reg != '0);
  assign head      = fifo_mem[rd_ptr_reg];
  assign req_floor = req_valid ? head : '0;
  assign count     = count_reg;
  assign full      = (count_reg == CW'(DEPTH));
  assign pop       = req_valid && req_ready;
  assign push      = push_found && !full;

  always_comb begin
    push_found  = 1'b0;
    push_idx    = '0;
    push_onehot = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (staged_reg[i] && !push_found) begin
        push_found     = 1'b1;
        push_idx       = FLOOR_W'(i);
        push_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pop_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      pop_mask[i] = pop && (head == FLOOR_W'(i));
    end
  end

  // A floor whose lamp is lit (staged or queued) never re-enters staging, so the
  // push bit and the pop bit can never collide.
  always_comb begin
    staged_next = (staged_reg & ~(push ? push_onehot : '0)) | (accept & ~lamp);
    queued_next = (queued_reg | (push ? push_onehot : '0)) & ~pop_mask;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= push_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      staged_reg <= '0;
      queued_reg <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      staged_reg <= staged_next;
      queued_reg <= queued_next;
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_request_queue.sv
// Randomised + directed bench for elevator_request_queue against a queue-based
// reference model that tracks synchronised run lengths instead of debounce states.
module tb_elevator_request_queue;

  localparam int NF    = 7;
  localparam int FW    = 7;
  localparam int DEPTH = 8;
  localparam int DEB   = 4;

  logic          clk;
  logic          reset;
  logic [NF-1:0] button;
  logic          req_ready;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic [NF-1:0] lamp;
  logic [3:0]    count;
  logic          full;

  elevator_request_queue #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .DEPTH(DEPTH), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset(reset), .button(button), .req_ready(req_ready),
    .req_valid(req_valid), .req_floor(req_floor), .lamp(lamp),
    .count(count), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int            q[$];
  logic [NF-1:0] stg;
  logic [NF-1:0] s1m, s2m;
  int            run[NF];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NF-1:0] qmask();
    logic [NF-1:0] m;
    m = '0;
    foreach (q[k]) m[q[k]] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    q.delete();
    stg = '0;
    s1m = '0;
    s2m = '0;
    for (int i = 0; i < NF; i++) run[i] = 0;
  endtask

  // Accept fires when the synchronised button has been high for exactly DEB cycles.
  task automatic model_edge();
    logic [NF-1:0] acc, lamp_pre;
    bit pop, push;
    if (!reset) begin
      model_clear();
      return;
    end
    lamp_pre = stg | qmask();
    for (int i = 0; i < NF; i++) acc[i] = (run[i] == DEB);
    pop  = (q.size() > 0) && req_ready;
    push = (stg != '0) && (q.size() < DEPTH);
    if (pop) void'(q.pop_front());
    if (push) begin
      for (int i = 0; i < NF; i++) begin
        if (stg[i]) begin
          q.push_back(i);
          stg[i] = 1'b0;
          break;
        end
      end
    end
    stg = stg | (acc & ~lamp_pre);
    s2m = s1m;
    s1m = button;
    for (int i = 0; i < NF; i++) run[i] = s2m[i] ? run[i] + 1 : 0;
  endtask

  task automatic check_model();
    check("valid", 32'(req_valid), 32'(q.size() > 0));
    check("floor", 32'(req_floor), (q.size() > 0) ? 32'(q[0]) : 32'd0);
    check("count", 32'(count), 32'(q.size()));
    check("full",  32'(full), 32'(q.size() == DEPTH));
    check("lamp",  32'(lamp), 32'(stg | qmask()));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  // Called just after an edge; asserts reset between edges and checks outputs at once.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_valid", 32'(req_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_lamp",  32'(lamp), 0);
    check("rst_floor", 32'(req_floor), 0);
    check("rst_full",  32'(full), 0);
    model_clear();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic press(input logic [NF-1:0] m, input int hold, input int settle);
    button = m;
    repeat (hold) step();
    button = '0;
    repeat (settle) step();
  endtask

  task automatic pop_one();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    button = '0;
    req_ready = 1'b0;
    model_clear();
    #12;
    check("init_valid", 32'(req_valid), 0);
    check("init_count", 32'(count), 0);
    check("init_lamp",  32'(lamp), 0);
    step();
    step();
    reset = 1'b1;
    repeat (2) step();

    // single press of floor 2
    button = 7'b0000100;
    repeat (5) step();
    check("sp_lamp_e5", 32'(lamp), 0);
    step();
    check("sp_lamp_e6", 32'(lamp), 32'b0000100);
    check("sp_valid_e6", 32'(req_valid), 0);
    step();
    check("sp_valid_e7", 32'(req_valid), 1);
    check("sp_floor_e7", 32'(req_floor), 2);
    check("sp_count_e7", 32'(count), 1);
    repeat (3) step();
    button = '0;
    pop_one();
    check("sp_valid_pop", 32'(req_valid), 0);
    check("sp_lamp_pop", 32'(lamp), 0);
    check("sp_count_pop", 32'(count), 0);
    repeat (4) step();

    // glitch rejection then a real press on floor 3
    press(7'b0001000, 3, 8);
    check("gl_lamp", 32'(lamp), 0);
    press(7'b0001000, 10, 0);
    check("gl_count", 32'(count), 1);
    check("gl_floor", 32'(req_floor), 3);
    pop_one();
    repeat (4) step();

    // duplicate press and long hold on floor 5
    press(7'b0100000, 8, 4);
    press(7'b0100000, 8, 4);
    check("dup_count", 32'(count), 1);
    check("dup_lamp", 32'(lamp), 32'b0100000);
    pop_one();
    press(7'b0100000, 50, 4);
    check("hold_count", 32'(count), 1);
    pop_one();
    check("hold_drain", 32'(count), 0);
    repeat (4) step();

    // simultaneous presses: floors 1, 4, 6
    button = 7'b1010010;
    repeat (6) step();
    check("sim_lamp_staged", 32'(lamp), 32'b1010010);
    check("sim_count0", 32'(count), 0);
    repeat (3) step();
    button = '0;
    check("sim_count3", 32'(count), 3);
    check("sim_head1", 32'(req_floor), 1);
    req_ready = 1'b1;
    step();
    check("sim_head4", 32'(req_floor), 4);
    step();
    check("sim_head6", 32'(req_floor), 6);
    step();
    check("sim_empty", 32'(count), 0);
    req_ready = 1'b0;
    repeat (4) step();

    // concurrent push/pop
    press(7'b0000001, 8, 3);
    press(7'b0001000, 8, 3);
    check("cc_count2", 32'(count), 2);
    check("cc_head0", 32'(req_floor), 0);
    button = 7'b1000000;
    repeat (6) step();
    check("cc_lamp", 32'(lamp), 32'b1001001);
    button = '0;
    req_ready = 1'b1;
    step();
    check("cc_count_same", 32'(count), 2);
    check("cc_head3", 32'(req_floor), 3);
    step();
    check("cc_head6", 32'(req_floor), 6);
    step();
    check("cc_empty", 32'(count), 0);
    req_ready = 1'b0;
    repeat (4) step();

    // async reset with 3 queued and 1 staged
    press(7'b1010010, 6, 3);
    button = 7'b0000100;
    repeat (6) step();
    check("ar_count", 32'(count), 3);
    check("ar_lamp", 32'(lamp), 32'b1010110);
    button = '0;
    do_reset();
    repeat (10) step();
    check("ar_after_lamp", 32'(lamp), 0);
    check("ar_after_count", 32'(count), 0);

    // randomised traffic, with one reset mid-stream while buttons may be held
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NF; i++)
        if ($urandom_range(0, 7) == 0) button[i] = ~button[i];
      req_ready = ($urandom_range(0, 3) == 0);
      if (c == 400) do_reset();
      else step();
    end
    button = '0;
    req_ready = 1'b1;
    repeat (20) step();
    check("rnd_drain", 32'(count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
